hitbox_sweeper: RTL and testbench

Per-frame collision sequencer for the game logic. On a start pulse, it latches the player hitbox and walks an obstacle table held in a synchronous ROM, one entry at a time. For each entry it runs an inclusive axis-aligned overlap test against the player box, then reports a per-obstacle hit mask, an any-hit flag and a ground-contact result. It sits between the frame-tick generator and the player physics update, and drives the obstacle ROM read port.

---
 rtl/hitbox_sweeper_pkg.sv | 23 ++
 rtl/hitbox_sweeper_aabb_overlap.sv | 18 +
 rtl/hitbox_sweeper.sv | 125 ++++++++++++
 tb/tb_hitbox_sweeper.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hitbox_sweeper_pkg.sv
// Shared game types for the collision sweeper:
// coordinates, boxes and sequencer states.
package hitbox_sweeper_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x1;
    coord_t x2;
    coord_t y1;
    coord_t y2;
  } box_t;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_CHECK = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/hitbox_sweeper_aabb_overlap.sv
// Inclusive axis-aligned box overlap test.
// Touching edges count as overlap.
import hitbox_sweeper_pkg::*;

module aabb_overlap (
  input  box_t a,
  input  box_t b,
  output logic hit
);

  logic x_ok;
  logic y_ok;

  assign x_ok = (a.x2 >= b.x1) && (a.x1 <= b.x2);
  assign y_ok = (a.y1 <= b.y2) && (a.y2 >= b.y1);
  assign hit  = x_ok && y_ok;

endmodule

// File: rtl/hitbox_sweeper.sv
// Per-frame collision sequencer: walks the
// obstacle ROM and collects hit/ground results.
import hitbox_sweeper_pkg::*;

module hitbox_sweeper #(
  parameter int N_OBJ      = 8,
  parameter int IDX_W      = $clog2(N_OBJ),
  parameter int GROUND_TOL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [9:0]         p_x1,
  input  logic [9:0]         p_x2,
  input  logic [9:0]         p_y1,
  input  logic [9:0]         p_y2,
  output logic [IDX_W-1:0]   obs_addr,
  input  logic [9:0]         obs_x1,
  input  logic [9:0]         obs_x2,
  input  logic [9:0]         obs_y1,
  input  logic [9:0]         obs_y2,
  output logic               busy,
  output logic               done,
  output logic [N_OBJ-1:0]   hit_mask,
  output logic               any_hit,
  output logic               ground_hit,
  output logic [9:0]         ground_y
);

  localparam logic [COORD_W:0] TOL =
    (COORD_W+1)'(GROUND_TOL);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_OBJ-1);

  state_t           state;
  box_t             pl;
  box_t             ob;
  logic [IDX_W-1:0] idx;
  logic             ovl;
  logic             gnd;
  logic             last;
  logic [COORD_W:0] y_lim;

  assign ob = '{
    x1: obs_x1,
    x2: obs_x2,
    y1: obs_y1,
    y2: obs_y2
  };

  aabb_overlap u_ovl (
    .a   (pl),
    .b   (ob),
    .hit (ovl)
  );

  // Extra bit keeps y1+TOL from wrapping near the bottom edge.
  assign y_lim = {1'b0, obs_y1} + TOL;
  assign gnd   = ovl && !ground_hit &&
                 ({1'b0, pl.y2} <= y_lim);
  assign last  = (idx == LAST);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pl         <= '0;
      idx        <= '0;
      obs_addr   <= '0;
      hit_mask   <= '0;
      any_hit    <= 1'b0;
      ground_hit <= 1'b0;
      ground_y   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pl <= '{
              x1: p_x1,
              x2: p_x2,
              y1: p_y1,
              y2: p_y2
            };
            hit_mask   <= '0;
            any_hit    <= 1'b0;
            ground_hit <= 1'b0;
            ground_y   <= '0;
            idx        <= '0;
            obs_addr   <= '0;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (ovl) begin
            hit_mask[idx] <= 1'b1;
            any_hit       <= 1'b1;
          end
          if (gnd) begin
            ground_hit <= 1'b1;
            ground_y   <= obs_y1;
          end
          if (last) begin
            state <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            obs_addr <= obs_addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hitbox_sweeper.sv
// Bench for hitbox_sweeper: vector table with a
// scoreboard queue plus reset/ignored-start sequences.
import hitbox_sweeper_pkg::*;

module tb_hitbox_sweeper;

  localparam int N  = 8;
  localparam int NV = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] p_x1 = '0;
  logic [9:0] p_x2 = '0;
  logic [9:0] p_y1 = '0;
  logic [9:0] p_y2 = '0;
  logic [2:0] obs_addr;
  logic [9:0] obs_x1;
  logic [9:0] obs_x2;
  logic [9:0] obs_y1;
  logic [9:0] obs_y2;
  logic       busy;
  logic       done;
  logic [7:0] hit_mask;
  logic       any_hit;
  logic       ground_hit;
  logic [9:0] ground_y;

  always #5 clk = ~clk;

  box_t rom [N];
  box_t rd;

  always_ff @(posedge clk) rd <= rom[obs_addr];

  assign obs_x1 = rd.x1;
  assign obs_x2 = rd.x2;
  assign obs_y1 = rd.y1;
  assign obs_y2 = rd.y2;

  hitbox_sweeper #(
    .N_OBJ      (N),
    .GROUND_TOL (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .p_x1       (p_x1),
    .p_x2       (p_x2),
    .p_y1       (p_y1),
    .p_y2       (p_y2),
    .obs_addr   (obs_addr),
    .obs_x1     (obs_x1),
    .obs_x2     (obs_x2),
    .obs_y1     (obs_y1),
    .obs_y2     (obs_y2),
    .busy       (busy),
    .done       (done),
    .hit_mask   (hit_mask),
    .any_hit    (any_hit),
    .ground_hit (ground_hit),
    .ground_y   (ground_y)
  );

  typedef struct packed {
    logic [7:0] mask;
    logic       any;
    logic       gh;
    logic [9:0] gy;
  } exp_t;

  typedef struct packed {
    box_t             pl;
    box_t [N-1:0]     rom;
    exp_t             ex;
  } vec_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   dones = 0;

  always @(negedge clk) if (done) dones++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  function automatic box_t mk(input int a, input int b,
                              input int c, input int d);
    box_t r;
    r.x1 = 10'(a);
    r.x2 = 10'(b);
    r.y1 = 10'(c);
    r.y2 = 10'(d);
    return r;
  endfunction

  // Caller is positioned at a negedge; start is driven now.
  task automatic sweep(input int v, input bit intrude);
    exp_t e;
    int   lat;
    int   d0;
    for (int i = 0; i < N; i++) rom[i] = vecs[v].rom[i];
    p_x1 = vecs[v].pl.x1;
    p_x2 = vecs[v].pl.x2;
    p_y1 = vecs[v].pl.y1;
    p_y2 = vecs[v].pl.y2;
    start = 1'b1;
    sb.push_back(vecs[v].ex);
    d0 = dones;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk($sformatf("v%0d busy_after_start", v), busy, 1);
    while (!done && lat < 60) begin
      if (intrude && lat == 5) begin
        p_x1 = 10'd0;
        p_x2 = 10'd1023;
        p_y1 = 10'd0;
        p_y2 = 10'd1023;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk($sformatf("v%0d latency", v), lat, 2*N+1);
    chk($sformatf("v%0d busy_in_done", v), busy, 1);
    chk($sformatf("v%0d addr_last", v), obs_addr, N-1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL v%0d scoreboard: got done want none", v);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d hit_mask", v), hit_mask, e.mask);
      chk($sformatf("v%0d any_hit", v), any_hit, e.any);
      chk($sformatf("v%0d ground_hit", v), ground_hit, e.gh);
      chk($sformatf("v%0d ground_y", v), ground_y, e.gy);
    end
    if (intrude) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d done_pulse", v), done, 0);
    chk($sformatf("v%0d busy_idle", v), busy, 0);
    chk($sformatf("v%0d mask_hold", v), hit_mask, e.mask);
    chk($sformatf("v%0d done_count", v), dones - d0, 1);
    if (intrude) begin
      repeat (25) @(negedge clk);
      chk($sformatf("v%0d no_extra_done", v),
          dones - d0, 1);
      chk($sformatf("v%0d still_idle", v), busy, 0);
    end
  endtask

  initial begin
    box_t far;
    int   d0;
    far = mk(1000, 1010, 0, 5);
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < N; i++) vecs[v].rom[i] = far;
      vecs[v].ex = '0;
    end
    vecs[0].pl     = mk(100, 120, 200, 240);
    vecs[0].rom[3] = mk(110, 300, 230, 260);
    vecs[0].ex     = '{mask: 8'h08, any: 1'b1,
                       gh: 1'b0, gy: 10'd0};
    vecs[1].pl     = mk(100, 150, 200, 240);
    vecs[1].rom[0] = mk(150, 200, 220, 300);
    vecs[1].ex     = '{mask: 8'h01, any: 1'b1,
                       gh: 1'b0, gy: 10'd0};
    vecs[2].pl     = mk(100, 150, 200, 240);
    vecs[2].rom[0] = mk(151, 200, 220, 300);
    vecs[3].pl     = mk(100, 150, 250, 302);
    vecs[3].rom[2] = mk(120, 130, 300, 400);
    vecs[3].rom[5] = mk(140, 160, 280, 400);
    vecs[3].ex     = '{mask: 8'h24, any: 1'b1,
                       gh: 1'b1, gy: 10'd300};
    vecs[4].pl     = mk(100, 150, 250, 302);
    vecs[4].rom[2] = mk(120, 130, 300, 400);
    vecs[4].rom[5] = mk(140, 160, 299, 400);
    vecs[4].ex     = '{mask: 8'h24, any: 1'b1,
                       gh: 1'b1, gy: 10'd300};
    vecs[5].pl     = mk(500, 600, 1000, 1023);
    vecs[5].rom[6] = mk(550, 560, 1022, 1023);
    vecs[5].ex     = '{mask: 8'h40, any: 1'b1,
                       gh: 1'b1, gy: 10'd1022};
    vecs[6].pl     = mk(100, 120, 200, 234);
    vecs[6].rom[1] = mk(100, 120, 230, 300);
    vecs[6].rom[4] = mk(90, 100, 229, 240);
    vecs[6].ex     = '{mask: 8'h12, any: 1'b1,
                       gh: 1'b1, gy: 10'd230};
    vecs[7].pl     = mk(100, 120, 200, 234);
    vecs[7].rom[1] = mk(100, 120, 229, 300);
    vecs[7].ex     = '{mask: 8'h02, any: 1'b1,
                       gh: 1'b0, gy: 10'd0};
    vecs[8].pl     = mk(10, 20, 10, 20);
    for (int i = 0; i < N; i++) rom[i] = far;

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst hit_mask", hit_mask, 0);
    chk("rst any_hit", any_hit, 0);
    chk("rst ground_hit", ground_hit, 0);
    chk("rst ground_y", ground_y, 0);
    chk("rst obs_addr", obs_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep(0, 1'b0);
    sweep(1, 1'b1);
    for (int v = 2; v < NV; v++) sweep(v, 1'b0);

    for (int i = 0; i < N; i++) rom[i] = vecs[1].rom[i];
    p_x1 = vecs[1].pl.x1;
    p_x2 = vecs[1].pl.x2;
    p_y1 = vecs[1].pl.y1;
    p_y2 = vecs[1].pl.y2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset hit_mask", hit_mask, 8'h01);
    d0 = dones;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst hit_mask", hit_mask, 0);
    chk("midrst any_hit", any_hit, 0);
    chk("midrst obs_addr", obs_addr, 0);
    chk("midrst done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst no_done", dones - d0, 0);
    chk("midrst idle", busy, 0);
    sweep(1, 1'b0);
    sweep(5, 1'b0);

    chk("scoreboard empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
